// File: rtl/mmio_xbar_pkg.sv
// Shared definitions for the MMIO interconnect: FSM states, slot map, defaults.
package mmio_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mmio_state_t;

   // Peripheral slot assignment
   localparam int unsigned SLV_GPIO  = 0;
   localparam int unsigned SLV_SPART = 1;
   localparam int unsigned SLV_BMP   = 2;
   localparam int unsigned SLV_SPARE = 3;

   // Default address map: slot i starts at MMIO_BASE_DEF + i * 2**SLOT_W_DEF
   localparam logic [15:0] MMIO_BASE_DEF = 16'hC000;
   localparam int unsigned SLOT_W_DEF    = 2;

endpackage

// File: rtl/mmio_xbar_if.sv
// Processor request/response and peripheral-side bus of the MMIO interconnect.
// 'slave' is the interconnect's own view, 'master' is the surrounding logic.
interface mmio_xbar_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned N_SLV  = 4,
   parameter int unsigned SLOT_W = 2
);
   logic                    req_valid;
   logic                    req_we;
   logic [ADDR_W-1:0]       req_addr;
   logic [DATA_W-1:0]       req_wdata;
   logic                    busy;
   logic                    resp_valid;
   logic [DATA_W-1:0]       resp_rdata;
   logic                    resp_err;
   logic [N_SLV-1:0]        s_sel;
   logic                    s_we;
   logic [SLOT_W-1:0]       s_addr;
   logic [DATA_W-1:0]       s_wdata;
   logic [N_SLV-1:0]        s_ready;
   logic [N_SLV*DATA_W-1:0] s_rdata;
   logic [ADDR_W-1:0]       err_addr;
   logic [7:0]              err_cnt;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, s_ready, s_rdata,
      output busy, resp_valid, resp_rdata, resp_err,
             s_sel, s_we, s_addr, s_wdata, err_addr, err_cnt
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, s_ready, s_rdata,
      input  busy, resp_valid, resp_rdata, resp_err,
             s_sel, s_we, s_addr, s_wdata, err_addr, err_cnt
   );
endinterface

// File: rtl/mmio_xbar_decode.sv
// Combinational address decode: word address -> {hit, slot index, word offset}.
module mmio_decode #(
   parameter int unsigned          ADDR_W    = 16,
   parameter int unsigned          N_SLV     = 4,
   parameter logic [ADDR_W-1:0]    MMIO_BASE = 16'hC000,
   parameter int unsigned          SLOT_W    = 2,
   parameter int unsigned          IDX_W     = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [IDX_W-1:0]  idx,
   output logic [SLOT_W-1:0] off
);
   logic [ADDR_W-1:0] rel;
   logic [ADDR_W-1:0] slot;

   // Offset from the window base, split into slot number and word offset
   always_comb begin
      rel  = addr - MMIO_BASE;
      slot = rel >> SLOT_W;
      hit  = (addr >= MMIO_BASE) && (slot < ADDR_W'(N_SLV));
      idx  = slot[IDX_W-1:0];
      off  = rel[SLOT_W-1:0];
   end
endmodule

// File: rtl/mmio_xbar.sv
// Registered request/response bridge between the processor data port and the
// peripheral slots, with wait states, timeout and sticky error capture.
module mmio_xbar
   import mmio_defs::*;
#(
   parameter int unsigned       ADDR_W    = 16,
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       N_SLV     = 4,
   parameter logic [ADDR_W-1:0] MMIO_BASE = MMIO_BASE_DEF,
   parameter int unsigned       SLOT_W    = SLOT_W_DEF,
   parameter int unsigned       TIMEOUT   = 15
) (
   input logic        clk,
   input logic        rst,
   mmio_xbar_if.slave bus
);
   localparam int unsigned IDX_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam logic [7:0]  TO_LIM = 8'(TIMEOUT);

   mmio_state_t       state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SLOT_W-1:0] off_q, off_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              dec_hit;
   logic [IDX_W-1:0]  dec_idx;
   logic [SLOT_W-1:0] dec_off;
   logic [DATA_W-1:0] sel_rdata;
   logic              sel_ready;
   logic              log_err;
   logic [ADDR_W-1:0] log_addr;

   mmio_decode #(
      .ADDR_W    (ADDR_W),
      .N_SLV     (N_SLV),
      .MMIO_BASE (MMIO_BASE),
      .SLOT_W    (SLOT_W),
      .IDX_W     (IDX_W)
   ) u_decode (
      .addr (bus.req_addr),
      .hit  (dec_hit),
      .idx  (dec_idx),
      .off  (dec_off)
   );

   // Only the latched slot's ready/data are looked at; other slots are ignored
   always_comb begin
      sel_ready = bus.s_ready[idx_q];
      sel_rdata = bus.s_rdata[32'(idx_q) * DATA_W +: DATA_W];
   end

   // Next-state, request latching, timeout counting and error capture
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      idx_d      = idx_q;
      off_d      = off_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;
      log_err    = 1'b0;
      log_addr   = addr_q;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = '0;
               if (dec_hit) begin
                  idx_d   = dec_idx;
                  off_d   = dec_off;
                  state_d = WAIT;
               end else begin
                  rdata_d  = '0;
                  err_d    = 1'b1;
                  log_err  = 1'b1;
                  log_addr = bus.req_addr;
                  state_d  = RESP;
               end
            end
         end
         WAIT: begin
            // Ready is tested before the limit so a same-cycle ready wins
            if (sel_ready) begin
               rdata_d = we_q ? '0 : sel_rdata;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = RESP;
            end else if (cnt_q == TO_LIM) begin
               rdata_d = '0;
               err_d   = 1'b1;
               cnt_d   = '0;
               log_err = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (log_err) begin
         err_addr_d = log_addr;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         idx_q      <= '0;
         off_q      <= '0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         idx_q      <= idx_d;
         off_q      <= off_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Bus outputs: slave strobes only in WAIT, response only in RESP
   always_comb begin
      bus.busy       = (state_q != IDLE);
      bus.resp_valid = (state_q == RESP);
      bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
      bus.resp_err   = (state_q == RESP) && err_q;
      bus.s_sel      = '0;
      if (state_q == WAIT) begin
         bus.s_sel[idx_q] = 1'b1;
      end
      bus.s_we       = (state_q == WAIT) && we_q;
      bus.s_addr     = off_q;
      bus.s_wdata    = wdata_q;
      bus.err_addr   = err_addr_q;
      bus.err_cnt    = err_cnt_q;
   end
endmodule

// File: tb/tb_mmio_xbar.sv
// Directed bench for mmio_xbar: zero-wait read, wait-state write, unmapped
// access, timeout with a foreign ready, reset mid-access, counter saturation.
module tb_mmio_xbar;
   import mmio_defs::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   mmio_xbar_if #(.ADDR_W(16), .DATA_W(16), .N_SLV(4), .SLOT_W(2)) bus ();

   mmio_xbar #(
      .ADDR_W    (16),
      .DATA_W    (16),
      .N_SLV     (4),
      .MMIO_BASE (16'hC000),
      .SLOT_W    (2),
      .TIMEOUT   (15)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] dec_addr;
   logic        dec_hit;
   logic [1:0]  dec_idx;
   logic [1:0]  dec_off;

   mmio_decode #(
      .ADDR_W    (16),
      .N_SLV     (4),
      .MMIO_BASE (16'hC000),
      .SLOT_W    (2),
      .IDX_W     (2)
   ) dec (
      .addr (dec_addr),
      .hit  (dec_hit),
      .idx  (dec_idx),
      .off  (dec_off)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
   endtask

   task automatic idle_req();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   logic [15:0] last_addr;

   initial begin
      idle_req();
      bus.s_ready = '0;
      // Distinct data per slot so a wrong slice shows up
      bus.s_rdata = {16'h3333, 16'h2222, 16'hA5A5, 16'h1111};

      // Decoder boundaries
      dec_addr = 16'hC000; #1;
      chk("dec_c000_hit", 32'(dec_hit), 32'd1);
      chk("dec_c000_idx", 32'(dec_idx), 32'(SLV_GPIO));
      dec_addr = 16'hC00F; #1;
      chk("dec_c00f_hit", 32'(dec_hit), 32'd1);
      chk("dec_c00f_idx", 32'(dec_idx), 32'(SLV_SPARE));
      chk("dec_c00f_off", 32'(dec_off), 32'd3);
      dec_addr = 16'hC010; #1;
      chk("dec_c010_hit", 32'(dec_hit), 32'd0);
      dec_addr = 16'hBFFF; #1;
      chk("dec_bfff_hit", 32'(dec_hit), 32'd0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy",     32'(bus.busy), 32'd0);
      chk("rst_rvalid",   32'(bus.resp_valid), 32'd0);
      chk("rst_sel",      32'(bus.s_sel), 32'd0);
      chk("rst_err_cnt",  32'(bus.err_cnt), 32'd0);
      chk("rst_err_addr", 32'(bus.err_addr), 32'd0);
      rst = 1'b0;

      // Zero-wait read of slot 1 word 2
      bus.s_ready = 4'b0010;
      issue(1'b0, 16'hC006, 16'h0);
      @(negedge clk);
      idle_req();
      chk("rd_sel",    32'(bus.s_sel), 32'b0010);
      chk("rd_saddr",  32'(bus.s_addr), 32'd2);
      chk("rd_swe",    32'(bus.s_we), 32'd0);
      chk("rd_busy",   32'(bus.busy), 32'd1);
      chk("rd_rv_n1",  32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      chk("rd_rv",     32'(bus.resp_valid), 32'd1);
      chk("rd_rdata",  32'(bus.resp_rdata), 32'hA5A5);
      chk("rd_err",    32'(bus.resp_err), 32'd0);
      chk("rd_sel_off", 32'(bus.s_sel), 32'd0);
      @(negedge clk);
      chk("rd_rv_done", 32'(bus.resp_valid), 32'd0);
      chk("rd_idle",    32'(bus.busy), 32'd0);

      // Write slot 2 with three wait states
      bus.s_ready = '0;
      issue(1'b1, 16'hC008, 16'h0123);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         idle_req();
         chk("wr_sel",   32'(bus.s_sel), 32'b0100);
         chk("wr_swe",   32'(bus.s_we), 32'd1);
         chk("wr_wdata", 32'(bus.s_wdata), 32'h0123);
         chk("wr_saddr", 32'(bus.s_addr), 32'd0);
         chk("wr_rv",    32'(bus.resp_valid), 32'd0);
         if (i == 4) bus.s_ready = 4'b0100;
      end
      @(negedge clk);
      bus.s_ready = '0;
      chk("wr_rv_n5", 32'(bus.resp_valid), 32'd1);
      chk("wr_err",   32'(bus.resp_err), 32'd0);
      chk("wr_rdata", 32'(bus.resp_rdata), 32'd0);
      chk("wr_swe_off", 32'(bus.s_we), 32'd0);
      @(negedge clk);

      // Unmapped read just past slot 3
      issue(1'b0, 16'hC010, 16'h0);
      @(negedge clk);
      idle_req();
      chk("um_rv",       32'(bus.resp_valid), 32'd1);
      chk("um_err",      32'(bus.resp_err), 32'd1);
      chk("um_rdata",    32'(bus.resp_rdata), 32'd0);
      chk("um_sel",      32'(bus.s_sel), 32'd0);
      chk("um_err_addr", 32'(bus.err_addr), 32'hC010);
      chk("um_err_cnt",  32'(bus.err_cnt), 32'd1);
      @(negedge clk);

      // Slot 0 never ready while slot 3 asserts ready: must time out
      bus.s_ready = 4'b1000;
      issue(1'b0, 16'hC000, 16'h0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         idle_req();
         chk("to_busy", 32'(bus.busy), 32'd1);
         chk("to_sel",  32'(bus.s_sel), 32'b0001);
         chk("to_rv",   32'(bus.resp_valid), 32'd0);
      end
      @(negedge clk);
      chk("to_rv_n17",   32'(bus.resp_valid), 32'd1);
      chk("to_busy_n17", 32'(bus.busy), 32'd1);
      chk("to_err",      32'(bus.resp_err), 32'd1);
      chk("to_rdata",    32'(bus.resp_rdata), 32'd0);
      chk("to_err_addr", 32'(bus.err_addr), 32'hC000);
      chk("to_err_cnt",  32'(bus.err_cnt), 32'd2);
      @(negedge clk);
      chk("to_idle", 32'(bus.busy), 32'd0);
      bus.s_ready = '0;

      // Reset on the second WAIT cycle of a slot 1 read
      issue(1'b0, 16'hC004, 16'h0);
      @(negedge clk);
      idle_req();
      chk("rw_sel1", 32'(bus.s_sel), 32'b0010);
      @(negedge clk);
      chk("rw_sel2", 32'(bus.s_sel), 32'b0010);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rw_sel",     32'(bus.s_sel), 32'd0);
      chk("rw_busy",    32'(bus.busy), 32'd0);
      chk("rw_rv",      32'(bus.resp_valid), 32'd0);
      chk("rw_err_cnt", 32'(bus.err_cnt), 32'd0);
      @(negedge clk);
      chk("rw_rv_after", 32'(bus.resp_valid), 32'd0);
      bus.s_ready = 4'b0010;
      bus.s_rdata = {16'h3333, 16'h2222, 16'h5A5A, 16'h1111};
      issue(1'b0, 16'hC006, 16'h0);
      @(negedge clk);
      idle_req();
      chk("rw2_sel", 32'(bus.s_sel), 32'b0010);
      @(negedge clk);
      chk("rw2_rv",    32'(bus.resp_valid), 32'd1);
      chk("rw2_rdata", 32'(bus.resp_rdata), 32'h5A5A);
      chk("rw2_err",   32'(bus.resp_err), 32'd0);
      @(negedge clk);
      bus.s_ready = '0;

      // 256 unmapped accesses: counter must stop at 255
      last_addr = '0;
      for (int i = 0; i < 256; i++) begin
         last_addr = (i % 2 == 0) ? 16'(16'hBFFF - 16'(i)) : 16'(16'hC010 + 16'(i));
         issue(1'b1, last_addr, 16'hFFFF);
         @(negedge clk);
         idle_req();
         if (i == 254) chk("sat_cnt_255", 32'(bus.err_cnt), 32'd255);
         if (i == 0)   chk("sat_first_err", 32'(bus.resp_err), 32'd1);
         @(negedge clk);
      end
      chk("sat_cnt_hold", 32'(bus.err_cnt), 32'd255);
      chk("sat_err_addr", 32'(bus.err_addr), 32'(last_addr));
      chk("sat_idle",     32'(bus.busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mmio_xbar.md
Name: mmio_xbar

Overview:
- Parametrised memory-mapped I/O interconnect between the processor data port and N peripheral slots (LEDs/switches, SPART, BMP display, future blocks).
- Replaces flat combinational address decode with a registered request/response bridge.
- Adds per-slave ready handshake (wait states), timeout, unmapped-access error response and sticky error capture.
- Sits in the top level between proc data-port glue and the peripheral register blocks; data-memory range is routed elsewhere and never reaches this block.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- N_SLV, 4, number of peripheral slots.
- MMIO_BASE, 16'hC000, address of slot 0, word 0.
- SLOT_W, 2, log2 words per slot; slot i occupies MMIO_BASE + i*2**SLOT_W.
- TIMEOUT, 15, max WAIT cycles before error; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  processor access request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- busy  out  1  request in flight; processor stalls
- resp_valid  out  1  one-cycle completion pulse (reads and writes)
- resp_rdata  out  DATA_W  read data, valid with resp_valid
- resp_err  out  1  unmapped or timed-out access, valid with resp_valid
- s_sel  out  N_SLV  one-hot slave select
- s_we  out  1  write strobe qualifier to selected slave
- s_addr  out  SLOT_W  word offset within slot
- s_wdata  out  DATA_W  write data to slave
- s_ready  in  N_SLV  per-slave completion
- s_rdata  in  N_SLV*DATA_W  per-slave read data, slot i at [i*DATA_W +: DATA_W]
- err_addr  out  ADDR_W  address of most recent errored access
- err_cnt  out  8  saturating error count

Behaviour:
- Reset, clk edge with rst=1: all outputs 0, state IDLE, timeout counter 0.
- rst has priority over all other events.
- Reset during WAIT/RESP: s_sel drops the next cycle and no resp_valid is issued.

FSM states: IDLE, WAIT, RESP.

- IDLE:
  - busy=0.
  - On req_valid, latch we/addr/wdata.
  - Decode: hit if req_addr >= MMIO_BASE and (req_addr-MMIO_BASE) >> SLOT_W < N_SLV.
  - Hit: go to WAIT, slot index latched.
  - Miss: go to RESP with err=1, rdata=0.
- WAIT:
  - s_sel[idx]=1; s_we/s_addr/s_wdata driven from latches, stable the whole state.
  - If s_ready[idx]=1: capture s_rdata slice (0 for writes), err=0, go to RESP.
  - Else increment counter; when counter==TIMEOUT with no ready, err=1, rdata=0, go to RESP.
  - Ready and timeout in the same cycle: ready wins, no error.
- RESP:
  - resp_valid=1 for exactly one cycle; s_sel=0; go to IDLE.
  - A new req_valid is not accepted until IDLE.
- busy = (state != IDLE).
- Latency:
  - Zero-wait slave (ready on first WAIT cycle): accept at cycle N, s_sel at N+1, resp_valid at N+2.
  - Unmapped access: resp_valid at N+1.
- s_ready of non-selected slaves is ignored.
- Error capture: each errored response loads err_addr and increments err_cnt, which saturates at 255 and never wraps.
- Address arithmetic is unsigned ADDR_W; no overflow past 16'hFFFF is considered.

Decomposition:
- Package mmio_defs:
  - mmio_state_t enum {IDLE, WAIT, RESP}.
  - Slot index constants SLV_GPIO=0, SLV_SPART=1, SLV_BMP=2, SLV_SPARE=3.
  - Default MMIO_BASE and SLOT_W.
- Sub-module mmio_decode: combinational, addr -> {hit, idx}, reused by the bench scoreboard.

Test Plan:
- Read slot 1 word 2 (addr C006), s_ready[1] tied 1, s_rdata slot1=16'hA5A5 -> s_sel=4'b0010 and s_addr=2 at N+1; resp_valid, rdata=A5A5, err=0 at N+2.
- Write C008 wdata 16'h0123, slot 2 ready after 3 wait cycles -> s_we=1 and s_wdata=0123 held 4 cycles; resp_valid at N+5, err=0.
- Read C010 (slot 4, N_SLV=4) -> resp_valid at N+1, err=1, rdata=0, s_sel never asserted, err_addr=C010, err_cnt=1.
- Slot 0 never ready, TIMEOUT=15 -> resp_valid with err=1 at N+17; busy high N+1..N+17.
- s_ready[3]=1 while slot 0 selected, and 256 unmapped accesses -> slot 3 ignored, timeout still occurs; err_cnt saturates at 255.
- rst asserted on the 2nd WAIT cycle -> outputs 0 the next cycle, no resp_valid; a subsequent read completes normally.
